// File: rtl/dss_pkg.sv
// Shared types and default timing constants for the DSS burst controller.
package dss_pkg;

    // Burst sequencing states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRE     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_TAIL    = 2'd3
    } dss_state_t;

    // Default chip timing: 8 clk per chip, 31 chips per symbol
    localparam int DSS_CHIP_DIV_DEF = 8;
    localparam int DSS_PN_LEN_DEF   = 31;

endpackage

// File: rtl/dss_chip_timer.sv
// Chip/symbol timebase: clk_cnt counts clk cycles within a chip, chip_cnt
// counts chips within a symbol. Both sit at zero while run is low, and are
// also zeroed on the edge where the burst is about to end (stop), so the
// idle block always restarts from a clean symbol boundary.
module dss_chip_timer
    import dss_pkg::*;
#(
    parameter int CHIP_DIV = DSS_CHIP_DIV_DEF,
    parameter int PN_LEN   = DSS_PN_LEN_DEF
)(
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic stop,
    output logic chip_en,
    output logic sym_en,
    output logic sym_last
);

    localparam int CLK_W  = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
    localparam int CHIP_W = (PN_LEN > 1) ? $clog2(PN_LEN) : 1;

    logic [CLK_W-1:0]  clk_cnt;
    logic [CHIP_W-1:0] chip_cnt;
    logic              clk_wrap;
    logic              chip_wrap;

    assign clk_wrap  = (clk_cnt == CLK_W'(CHIP_DIV - 1));
    assign chip_wrap = (chip_cnt == CHIP_W'(PN_LEN - 1));

    // Free-running chip/symbol counters, held at zero outside a burst
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_cnt  <= '0;
            chip_cnt <= '0;
        end else if (!run || stop) begin
            clk_cnt  <= '0;
            chip_cnt <= '0;
        end else if (clk_wrap) begin
            clk_cnt  <= '0;
            chip_cnt <= chip_wrap ? '0 : chip_cnt + CHIP_W'(1);
        end else begin
            clk_cnt  <= clk_cnt + CLK_W'(1);
        end
    end

    assign chip_en  = run && (clk_cnt == '0);
    assign sym_en   = chip_en && (chip_cnt == '0);
    assign sym_last = run && clk_wrap && chip_wrap;

endmodule

// File: rtl/dss_burst_ctrl.sv
// DSS burst controller: sequences an optional preamble, the payload symbols
// and a shaping-filter flush tail, generating chip/symbol strobes for the
// PN spreader and pulling one source bit per payload symbol.
// Optional feature: define DSS_PREAMBLE_EN to insert PRE_SYMS alternating
// 1,0,1,... preamble symbols ahead of the payload.
module dss_burst_ctrl
    import dss_pkg::*;
#(
    parameter int CHIP_DIV  = DSS_CHIP_DIV_DEF,
    parameter int PN_LEN    = DSS_PN_LEN_DEF,
    parameter int LEN_W     = 12,
    parameter int TAIL_CLKS = 64,
    parameter int PRE_SYMS  = 16
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             bit_valid,
    input  logic             bit_data,
    output logic             bit_ready,
    output logic             chip_en,
    output logic             sym_en,
    output logic             pn_load,
    output logic             sym_data,
    output logic             tx_active,
    output logic             underrun,
    output logic             done
);

    localparam int TAIL_W = (TAIL_CLKS > 1) ? $clog2(TAIL_CLKS) : 1;

    dss_state_t       state;
    dss_state_t       state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] sym_cnt;
    logic [TAIL_W-1:0] tail_cnt;
    logic             start_acc;
    logic             tmr_sym_en;
    logic             sym_last;
    logic             tail_last;
    logic             pay_last;
    logic             pay_sym;
    logic             stop;

`ifdef DSS_PREAMBLE_EN
    localparam int PRE_W = $clog2(PRE_SYMS + 1);
    logic [PRE_W-1:0] pre_cnt;
    logic             pre_last;
    logic             pre_sym;

    assign pre_last = sym_last && (pre_cnt == PRE_W'(PRE_SYMS));
    assign pre_sym  = (state == ST_PRE) && sym_en;
`else
    logic unused_pre_syms;
    assign unused_pre_syms = (PRE_SYMS != 0);
`endif

    assign tx_active = (state != ST_IDLE);
    assign start_acc = (state == ST_IDLE) && start && !abort;
    assign tail_last = (tail_cnt == TAIL_W'(TAIL_CLKS - 1));
    assign pay_last  = sym_last && (sym_cnt == len_q);
    assign stop      = (state_nxt == ST_IDLE);
    assign sym_en    = tmr_sym_en && ((state == ST_PRE) || (state == ST_PAYLOAD));
    assign pay_sym   = (state == ST_PAYLOAD) && sym_en;
    assign bit_ready = pay_sym;

    dss_chip_timer #(
        .CHIP_DIV (CHIP_DIV),
        .PN_LEN   (PN_LEN)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (tx_active),
        .stop     (stop),
        .chip_en  (chip_en),
        .sym_en   (tmr_sym_en),
        .sym_last (sym_last)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; abort overrides everything, including a start in IDLE
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
`ifdef DSS_PREAMBLE_EN
                        state_nxt = ST_PRE;
`else
                        state_nxt = (len == '0) ? ST_TAIL : ST_PAYLOAD;
`endif
                    end
                end
`ifdef DSS_PREAMBLE_EN
                ST_PRE: begin
                    if (pre_last) state_nxt = (len_q == '0) ? ST_TAIL : ST_PAYLOAD;
                end
`endif
                ST_PAYLOAD: begin
                    if (pay_last) state_nxt = ST_TAIL;
                end
                ST_TAIL: begin
                    if (tail_last) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Burst length latch and symbol/tail progress counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q    <= '0;
            sym_cnt  <= '0;
            tail_cnt <= '0;
        end else if (start_acc) begin
            len_q    <= len;
            sym_cnt  <= '0;
            tail_cnt <= '0;
        end else begin
            if (stop)         sym_cnt <= '0;
            else if (pay_sym) sym_cnt <= sym_cnt + LEN_W'(1);
            if ((state == ST_TAIL) && (state_nxt == ST_TAIL)) tail_cnt <= tail_cnt + TAIL_W'(1);
            else                                              tail_cnt <= '0;
        end
    end

`ifdef DSS_PREAMBLE_EN
    // Preamble symbol counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       pre_cnt <= '0;
        else if (start_acc) pre_cnt <= '0;
        else if (stop)      pre_cnt <= '0;
        else if (pre_sym)   pre_cnt <= pre_cnt + PRE_W'(1);
    end
`endif

    // Registered strobes and flags: reseed pulse, completion pulse, underrun
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pn_load  <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            pn_load <= start_acc;
            done    <= (state == ST_TAIL) && tail_last && !abort;
            if (start_acc)                  underrun <= 1'b0;
            else if (pay_sym && !bit_valid) underrun <= 1'b1;
        end
    end

    // Symbol bit: source bit (or 0 on underrun) at payload boundaries,
    // alternating pattern in preamble, forced 0 in tail and idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sym_data <= 1'b0;
        end else if ((state_nxt == ST_IDLE) || (state_nxt == ST_TAIL)) begin
            sym_data <= 1'b0;
        end else if (pay_sym) begin
            sym_data <= bit_valid & bit_data;
`ifdef DSS_PREAMBLE_EN
        end else if (pre_sym) begin
            sym_data <= ~pre_cnt[0];
`endif
        end
    end

endmodule

// File: tb/tb_dss_burst_ctrl.sv
// Directed bench for dss_burst_ctrl with default timing (8 clk/chip,
// 31 chips/symbol, 64-cycle tail). With DSS_PREAMBLE_EN defined the
// preamble scenario runs with PRE_SYMS=4.
`timescale 1ns/1ps
module tb_dss_burst_ctrl;

    localparam int LEN_W = 12;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             abort = 1'b0;
    logic             bit_valid = 1'b0;
    logic             bit_data = 1'b0;
    logic             bit_ready, chip_en, sym_en, pn_load, sym_data, tx_active, underrun, done;

    int n_vec = 0;
    int n_err = 0;

    // Burst observation results (cycle numbers relative to start cycle T)
    int   se_cyc[8];
    logic sd_after[8];
    int   se_n, done_cyc, done_n, idle_cyc, chip_n, pl_cyc, pl_n, rdy_first;
    logic ur_k1;

    dss_burst_ctrl #(
        .CHIP_DIV  (8),
        .PN_LEN    (31),
        .LEN_W     (LEN_W),
        .TAIL_CLKS (64),
        .PRE_SYMS  (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .bit_valid (bit_valid),
        .bit_data  (bit_data),
        .bit_ready (bit_ready),
        .chip_en   (chip_en),
        .sym_en    (sym_en),
        .pn_load   (pn_load),
        .sym_data  (sym_data),
        .tx_active (tx_active),
        .underrun  (underrun),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {24'd0, bit_ready, chip_en, sym_en, pn_load, sym_data, tx_active, underrun, done};
    endfunction

    // Issue start in the current cycle T, then observe cycles T+1..T+ncyc.
    // Bits are served from vmask/dbits on each bit_ready.
    task automatic run_burst(input int ncyc, input int l, input logic [7:0] vmask,
                             input logic [7:0] dbits, input int abort_at, input int restart_at);
        int idx;
        int pend;
        idx = 0; pend = -1;
        se_n = 0; done_cyc = -1; done_n = 0; idle_cyc = -1; chip_n = 0;
        pl_cyc = -1; pl_n = 0; rdy_first = -1; ur_k1 = 1'bx;
        for (int i = 0; i < 8; i++) begin
            se_cyc[i] = -1;
            sd_after[i] = 1'bx;
        end
        start = 1'b1;
        len = LEN_W'(l);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            if (k == 1) ur_k1 = underrun;
            if (pend >= 0) begin
                sd_after[pend] = sym_data;
                pend = -1;
            end
            if (sym_en) begin
                if (se_n < 8) begin
                    se_cyc[se_n] = k;
                    pend = se_n;
                end
                se_n++;
            end
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (!tx_active && idle_cyc < 0) idle_cyc = k;
            if (chip_en) chip_n++;
            if (pn_load) begin
                pl_n++;
                if (pl_cyc < 0) pl_cyc = k;
            end
            bit_valid = 1'b0;
            bit_data = 1'b0;
            if (bit_ready) begin
                if (rdy_first < 0) rdy_first = k;
                if (idx < 8) begin
                    bit_valid = vmask[idx];
                    bit_data = dbits[idx];
                end
                idx++;
            end
            abort = (k == abort_at);
            start = (k == restart_at);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        bit_valid = 1'b0;
        bit_data = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outs", outs(), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_outs", outs(), 32'd0);

`ifdef DSS_PREAMBLE_EN
        // Preamble 4 symbols then one payload bit
        run_burst(1320, 1, 8'h01, 8'h01, -1, -1);
        check_eq("pre_pn_load", pl_cyc, 1);
        check_eq("pre_sym_n", se_n, 5);
        check_eq("pre_se0", se_cyc[0], 1);
        check_eq("pre_se1", se_cyc[1], 249);
        check_eq("pre_se3", se_cyc[3], 745);
        check_eq("pre_sd0", sd_after[0], 1);
        check_eq("pre_sd1", sd_after[1], 0);
        check_eq("pre_sd2", sd_after[2], 1);
        check_eq("pre_sd3", sd_after[3], 0);
        check_eq("pre_rdy_first", rdy_first, 993);
        check_eq("pre_sd_payload", sd_after[4], 1);
        check_eq("pre_done", done_cyc, 1305);
`else
        // Nominal three-symbol burst, bits 1,0,1
        run_burst(820, 3, 8'h07, 8'h05, -1, -1);
        check_eq("b3_pn_load", pl_cyc, 1);
        check_eq("b3_pn_load_n", pl_n, 1);
        check_eq("b3_sym_n", se_n, 3);
        check_eq("b3_se0", se_cyc[0], 1);
        check_eq("b3_se1", se_cyc[1], 249);
        check_eq("b3_se2", se_cyc[2], 497);
        check_eq("b3_sd0", sd_after[0], 1);
        check_eq("b3_sd1", sd_after[1], 0);
        check_eq("b3_sd2", sd_after[2], 1);
        check_eq("b3_done", done_cyc, 809);
        check_eq("b3_done_n", done_n, 1);
        check_eq("b3_idle", idle_cyc, 809);
        check_eq("b3_chip_n", chip_n, 101);
        check_eq("b3_underrun", underrun, 0);

        // Underrun on second symbol
        run_burst(600, 2, 8'h01, 8'h03, -1, -1);
        check_eq("ur_sd0", sd_after[0], 1);
        check_eq("ur_sd1", sd_after[1], 0);
        check_eq("ur_done", done_cyc, 561);
        check_eq("ur_flag_held", underrun, 1);

        // Zero-length burst: tail only; start clears underrun
        run_burst(80, 0, 8'h00, 8'h00, -1, -1);
        check_eq("z_ur_cleared", ur_k1, 0);
        check_eq("z_sym_n", se_n, 0);
        check_eq("z_chip_n", chip_n, 8);
        check_eq("z_done", done_cyc, 65);
        check_eq("z_idle", idle_cyc, 65);

        // start and abort together in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_eq("sa_active", tx_active, 0);
        check_eq("sa_pn_load", pn_load, 0);
        @(negedge clk);
        check_eq("sa_active2", tx_active, 0);

        // Abort mid-burst; a second start during the burst is ignored
        run_burst(400, 3, 8'h07, 8'h07, 300, 100);
        check_eq("ab_idle", idle_cyc, 301);
        check_eq("ab_done_n", done_n, 0);
        check_eq("ab_pn_load_n", pl_n, 1);
        check_eq("ab_sym_n", se_n, 2);
        check_eq("ab_chip_n", chip_n, 38);
        check_eq("ab_sym_data", sym_data, 0);

        // Reset mid-burst, then a fresh burst
        run_burst(99, 3, 8'h07, 8'h07, -1, -1);
        check_eq("rs_pre_active", tx_active, 1);
        check_eq("rs_pre_sd", sym_data, 1);
        reset_n = 1'b0;
        #1;
        check_eq("rs_outs", outs(), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rs_wait", tx_active, 0);
        run_burst(820, 3, 8'h07, 8'h05, -1, -1);
        check_eq("rs_pn_load", pl_cyc, 1);
        check_eq("rs_se0", se_cyc[0], 1);
        check_eq("rs_se2", se_cyc[2], 497);
        check_eq("rs_done", done_cyc, 809);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
